// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the flow-table memory port arbiter: bus widths,
// arbiter state encoding and parameter defaults.
package mem_arbiter_pkg;

    localparam int   ADDR_BUS = 32;
    localparam int   DATA_BUS = 32;
    localparam logic TRUE     = 1'b1;
    localparam logic FALSE    = 1'b0;

    localparam int NUM_REQ_DEF  = 4;
    localparam int MAX_HOLD_DEF = 256;

    typedef enum logic {
        IDLE,
        OWNED
    } ARB_STATE;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bundle of the arbiter. The slave modport is
// the arbiter's view; master is the view of the engines plus memory model.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
);
    logic [NUM_REQ-1:0]               req_ce_i;
    logic [NUM_REQ-1:0]               req_we_i;
    logic [NUM_REQ-1:0][ADDR_BUS-1:0] req_addr_i;
    logic [NUM_REQ-1:0][3:0]          req_width_i;
    logic [NUM_REQ-1:0][DATA_BUS-1:0] req_data_i;
    logic [NUM_REQ-1:0]               req_ready_o;
    logic [DATA_BUS-1:0]              req_data_o;

    logic                mem_ce_o;
    logic                mem_we_o;
    logic [ADDR_BUS-1:0] mem_addr_o;
    logic [3:0]          mem_width_o;
    logic [DATA_BUS-1:0] mem_data_o;
    logic [DATA_BUS-1:0] mem_data_i;
    logic                mem_ready_i;

    modport slave (
        input  req_ce_i, req_we_i, req_addr_i, req_width_i, req_data_i,
        input  mem_data_i, mem_ready_i,
        output req_ready_o, req_data_o,
        output mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o
    );

    modport master (
        output req_ce_i, req_we_i, req_addr_i, req_width_i, req_data_i,
        output mem_data_i, mem_ready_i,
        input  req_ready_o, req_data_o,
        input  mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o
    );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin picker: first set bit of req scanning upward from ptr with
// wrap-around, returned one-hot together with a found flag.
module rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       valid
);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && req[(int'(ptr) + i) % NUM_REQ]) begin
                grant[(int'(ptr) + i) % NUM_REQ] = 1'b1;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin owner of the single flow-table memory port. An engine keeps the
// grant for as long as it holds chip-enable; the port is then muxed straight through.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic               clk,
    input  logic               rst,
    mem_arbiter_if.slave       bus,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               busy_o,
    output logic               timeout_o
);

    localparam int                PTR_W     = $clog2(NUM_REQ);
    localparam int                HOLD_W    = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(NUM_REQ - 1);

    ARB_STATE           state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   pick_idx;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_vld;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req   (bus.req_ce_i),
        .ptr   (rr_ptr),
        .grant (pick_oh),
        .valid (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (pick_oh[i]) pick_idx = PTR_W'(i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            grant_o   <= '0;
            busy_o    <= FALSE;
            owner     <= '0;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
            timeout_o <= FALSE;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state    <= OWNED;
                        grant_o  <= pick_oh;
                        busy_o   <= TRUE;
                        owner    <= pick_idx;
                        hold_cnt <= '0;
                    end
                end
                OWNED: begin
                    if (!bus.req_ce_i[owner]) begin
                        state    <= IDLE;
                        grant_o  <= '0;
                        busy_o   <= FALSE;
                        rr_ptr   <= (owner == LAST_IDX) ? '0 : owner + PTR_W'(1);
                        hold_cnt <= '0;
                    end else begin
                        // hold_cnt counts held cycles already completed; this one is number hold_cnt+1
                        if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HOLD_W'(1);
                        if (hold_cnt >= HOLD_LAST) timeout_o <= TRUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Owner path is purely combinational so each beat reaches memory with no added latency.
    always_comb begin
        bus.mem_ce_o    = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_width_o = '0;
        bus.mem_data_o  = '0;
        if (state == OWNED) begin
            bus.mem_ce_o    = bus.req_ce_i[owner];
            bus.mem_we_o    = bus.req_we_i[owner];
            bus.mem_addr_o  = bus.req_addr_i[owner];
            bus.mem_width_o = bus.req_width_i[owner];
            bus.mem_data_o  = bus.req_data_i[owner];
        end
    end

    assign bus.req_ready_o = grant_o & {NUM_REQ{bus.mem_ready_i}};
    assign bus.req_data_o  = bus.mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, multi-cycle sequences, and a
// randomized run against an integer-level reference model of the arbitration rules.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int MH = 8;

    typedef struct {
        logic [N-1:0] ce;
        logic         rdy;
        logic [N-1:0] exp_grant;
        logic         exp_ce;
        logic [N-1:0] exp_rdy;
        logic [31:0]  exp_addr;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] grant;
    logic         busy;
    logic         tmo;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // reference model: owner index (-1 idle), next-search pointer, held cycles, sticky flag
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_tmo   = 1'b0;

    // requester agents: tenures < 0 means request forever
    int hold_len[N];
    int tenures[N];
    int gcnt[N];
    bit rnd_mode = 1'b0;

    logic [N-1:0] prev_grant = '0;
    int           glog[$];
    vec_t         tbl[13];

    mem_arbiter_if #(.NUM_REQ(N)) bus ();

    mem_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .grant_o   (grant),
        .busy_o    (busy),
        .timeout_o (tmo)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int first_grant();
        if (glog.size() == 0) return -1;
        return glog[0];
    endfunction

    task automatic model_edge();
        if (!rst) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_tmo = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (bus.req_ce_i[j]) begin
                    m_owner = j;
                    break;
                end
            end
            m_held = 0;
        end else if (!bus.req_ce_i[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_held  = 0;
        end else begin
            m_held++;
            if (m_held >= MH) m_tmo = 1'b1;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        if (grant != '0 && prev_grant == '0) glog.push_back(oh_idx(grant));
        prev_grant = grant;
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0]  eg;
        logic          e_ce, e_we;
        logic [31:0]   e_addr, e_data;
        logic [3:0]    e_w;
        eg = '0; e_ce = 1'b0; e_we = 1'b0; e_addr = '0; e_data = '0; e_w = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            e_ce   = bus.req_ce_i[m_owner];
            e_we   = bus.req_we_i[m_owner];
            e_addr = bus.req_addr_i[m_owner];
            e_w    = bus.req_width_i[m_owner];
            e_data = bus.req_data_i[m_owner];
        end
        cmp({tag, "_grant"}, 64'(grant), 64'(eg));
        cmp({tag, "_busy"}, 64'(busy), 64'(m_owner >= 0));
        cmp({tag, "_mem_ce"}, 64'(bus.mem_ce_o), 64'(e_ce));
        cmp({tag, "_mem_we"}, 64'(bus.mem_we_o), 64'(e_we));
        cmp({tag, "_mem_addr"}, 64'(bus.mem_addr_o), 64'(e_addr));
        cmp({tag, "_mem_width"}, 64'(bus.mem_width_o), 64'(e_w));
        cmp({tag, "_mem_data"}, 64'(bus.mem_data_o), 64'(e_data));
        cmp({tag, "_ready"}, 64'(bus.req_ready_o), 64'(eg & {N{bus.mem_ready_i}}));
        cmp({tag, "_rdata"}, 64'(bus.req_data_o), 64'(bus.mem_data_i));
        cmp({tag, "_timeout"}, 64'(tmo), 64'(m_tmo));
    endtask

    // Each agent holds ce for hold_len granted cycles, then drops it for at least one cycle.
    task automatic agent_step();
        for (int i = 0; i < N; i++) begin
            if (bus.req_ce_i[i] && grant[i]) begin
                if (gcnt[i] >= hold_len[i]) begin
                    bus.req_ce_i[i] = 1'b0;
                    gcnt[i] = 0;
                    if (tenures[i] > 0) tenures[i]--;
                end else begin
                    gcnt[i]++;
                end
            end else if (!bus.req_ce_i[i] && !grant[i] && tenures[i] != 0) begin
                if (!rnd_mode || $urandom_range(0, 2) == 0) begin
                    bus.req_ce_i[i] = 1'b1;
                    gcnt[i] = 0;
                    if (rnd_mode) hold_len[i] = int'($urandom_range(1, 11));
                end
            end else if (rnd_mode && bus.req_ce_i[i] && !grant[i] && $urandom_range(0, 15) == 0) begin
                bus.req_ce_i[i] = 1'b0;
            end
        end
    endtask

    task automatic drive_mem();
        bus.mem_ready_i = 1'($urandom_range(0, 1));
        bus.mem_data_i  = $urandom();
        if (rnd_mode) begin
            for (int i = 0; i < N; i++) begin
                bus.req_we_i[i]    = 1'($urandom_range(0, 1));
                bus.req_addr_i[i]  = $urandom();
                bus.req_width_i[i] = 4'($urandom_range(1, 8));
                bus.req_data_i[i]  = $urandom();
            end
        end
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) begin
            agent_step();
            drive_mem();
            #2;
            check_model(tag);
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        rnd_mode = 1'b0;
        bus.req_ce_i    = '0;
        bus.mem_ready_i = 1'b0;
        bus.mem_data_i  = '0;
        for (int i = 0; i < N; i++) begin
            tenures[i] = 0; gcnt[i] = 0; hold_len[i] = 1;
            bus.req_we_i[i]    = 1'(i);
            bus.req_addr_i[i]  = (i == 2) ? 32'h40 : 32'(i * 32'h100);
            bus.req_width_i[i] = 4'd4;
            bus.req_data_i[i]  = 32'(32'hD0 + i);
        end
        tick();
        tick();
        #2 rst = 1'b1;
        tick();
        cmp("rst_grant", 64'(grant), 64'(0));
        cmp("rst_busy", 64'(busy), 64'(0));
        cmp("rst_timeout", 64'(tmo), 64'(0));
        cmp("rst_mem_ce", 64'(bus.mem_ce_o), 64'(0));
        glog.delete();
    endtask

    initial begin : main
        int g, tt;
        logic [N-1:0] gt;

        // single request from req 2: ce rises at cycle 5, held 6 cycles, ready on even cycles
        for (int c = 0; c < 5; c++) tbl[c] = '{4'b0000, 1'(c % 2 == 0), 4'b0000, 1'b0, 4'b0000, 32'h0};
        tbl[5]  = '{4'b0100, 1'b0, 4'b0000, 1'b0, 4'b0000, 32'h0};
        tbl[6]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100, 32'h40};
        tbl[7]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0000, 32'h40};
        tbl[8]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100, 32'h40};
        tbl[9]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0000, 32'h40};
        tbl[10] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100, 32'h40};
        tbl[11] = '{4'b0000, 1'b0, 4'b0100, 1'b0, 4'b0000, 32'h40};
        tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 32'h0};

        do_reset();
        for (int k = 0; k < 13; k++) begin
            bus.req_ce_i    = tbl[k].ce;
            bus.mem_ready_i = tbl[k].rdy;
            bus.mem_data_i  = $urandom();
            #2;
            cmp("tbl_grant", 64'(grant), 64'(tbl[k].exp_grant));
            cmp("tbl_mem_ce", 64'(bus.mem_ce_o), 64'(tbl[k].exp_ce));
            cmp("tbl_ready", 64'(bus.req_ready_o), 64'(tbl[k].exp_rdy));
            cmp("tbl_mem_addr", 64'(bus.mem_addr_o), 64'(tbl[k].exp_addr));
            check_model("tbl");
            tick();
        end

        // simultaneous requests 0, 1, 3
        do_reset();
        tenures[0] = 1; tenures[1] = 1; tenures[3] = 1;
        hold_len[0] = 4; hold_len[1] = 4; hold_len[3] = 4;
        run(30, "simul");
        cmp("simul_count", 64'(glog.size()), 64'(3));
        for (int k = 0; k < 3; k++)
            cmp("simul_order", 64'((k < glog.size()) ? glog[k] : -1), 64'((k == 2) ? 3 : k));
        // pointer must be back at 0: req 0 beats req 2
        glog.delete();
        tenures[0] = 1; tenures[2] = 1; hold_len[0] = 2; hold_len[2] = 2;
        run(16, "simul_ptr");
        cmp("simul_ptr_first", 64'(first_grant()), 64'(0));

        // fairness: req 0 re-requests at once, req 3 continuously
        do_reset();
        tenures[0] = -1; hold_len[0] = 2;
        tenures[3] = -1; hold_len[3] = 3;
        run(60, "fair");
        cmp("fair_enough_grants", 64'(glog.size() >= 8), 64'(1));
        for (int k = 0; k < 8; k++)
            cmp("fair_order", 64'((k < glog.size()) ? glog[k] : -1), 64'((k % 2 == 1) ? 3 : 0));

        // ready masking: req 1 owns while req 2 waits
        do_reset();
        tenures[1] = 1; hold_len[1] = 6;
        run(1, "mask");
        tenures[2] = 1; hold_len[2] = 2;
        repeat (8) begin
            agent_step();
            drive_mem();
            bus.mem_ready_i = cyc[0];
            #2;
            check_model("mask");
            if (grant == 4'b0010 && bus.mem_ready_i)
                cmp("mask_ready", 64'(bus.req_ready_o), 64'(4'b0010));
            tick();
        end
        run(20, "mask_tail");

        // timeout: req 0 holds for 12 cycles with MAX_HOLD = 8
        do_reset();
        tenures[0] = 1; hold_len[0] = 12;
        g = -1; tt = -1; gt = '0;
        for (int k = 0; k < 30; k++) begin
            agent_step();
            drive_mem();
            #2;
            check_model("tmo");
            if (grant[0] && g < 0) g = cyc;
            if (tmo && tt < 0) begin
                tt = cyc;
                gt = grant;
            end
            tick();
        end
        cmp("tmo_latency", 64'(tt - g), 64'(8));
        cmp("tmo_grant_kept", 64'(gt), 64'(4'b0001));
        cmp("tmo_sticky", 64'(tmo), 64'(1));
        cmp("tmo_released", 64'(grant), 64'(0));

        // asynchronous reset during req 1 ownership
        do_reset();
        tenures[1] = 1; hold_len[1] = 20;
        run(12, "prerst");
        cmp("prerst_owner", 64'(grant), 64'(4'b0010));
        cmp("prerst_timeout", 64'(tmo), 64'(1));
        bus.mem_ready_i = 1'b1;
        #3 rst = 1'b0;
        #1;
        cmp("arst_grant", 64'(grant), 64'(0));
        cmp("arst_busy", 64'(busy), 64'(0));
        cmp("arst_mem_ce", 64'(bus.mem_ce_o), 64'(0));
        cmp("arst_mem_addr", 64'(bus.mem_addr_o), 64'(0));
        cmp("arst_ready", 64'(bus.req_ready_o), 64'(0));
        cmp("arst_timeout", 64'(tmo), 64'(0));
        m_owner = -1; m_ptr = 0; m_held = 0; m_tmo = 1'b0;
        bus.req_ce_i = '0;
        for (int i = 0; i < N; i++) begin
            tenures[i] = 0; gcnt[i] = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        prev_grant = grant;
        #2 rst = 1'b1;
        glog.delete();
        tenures[3] = 1; hold_len[3] = 2;
        run(10, "postrst");
        cmp("postrst_first", 64'(first_grant()), 64'(3));

        // randomized traffic against the model
        do_reset();
        rnd_mode = 1'b1;
        for (int i = 0; i < N; i++) tenures[i] = -1;
        run(500, "rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
